// File: rtl/bfly_pair_buf.sv
// Radix-2 pairing buffer: stores the first half of each frame and presents every
// second-half block alongside its stored partner as registered butterfly operands.
module bfly_pair_buf #(
   parameter int INT   = 3,
   parameter int FLT   = 6,
   parameter int WIDTH = INT + FLT,
   parameter int DEPTH = 4,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] din_re   [15:0],
   input  logic signed [WIDTH-1:0] din_im   [15:0],
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] dout1_re [15:0],
   output logic signed [WIDTH-1:0] dout1_im [15:0],
   output logic signed [WIDTH-1:0] dout2_re [15:0],
   output logic signed [WIDTH-1:0] dout2_im [15:0],
   output logic [IW-1:0]           pair_idx,
   output logic                    frame_done
);

   typedef enum logic {FILL, PAIR} state_t;

   state_t        state_reg;
   logic [IW-1:0] cnt_reg;
   logic          last_blk;
   logic          wr_en;
   logic          rd_en;

   assign last_blk = (cnt_reg == IW'(DEPTH - 1));
   // FILL only writes and PAIR only reads, so one address serves both ports.
   assign wr_en    = !rst && !flush && in_valid && (state_reg == FILL);
   assign rd_en    = !rst && !flush && in_valid && (state_reg == PAIR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= FILL;
         cnt_reg    <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         pair_idx   <= '0;
      end else if (flush) begin
         state_reg  <= FILL;
         cnt_reg    <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (in_valid) begin
            // DEPTH is a power of two, so the increment wraps to 0 on the last block.
            cnt_reg <= cnt_reg + IW'(1);
            case (state_reg)
               FILL: begin
                  if (last_blk) state_reg <= PAIR;
               end
               PAIR: begin
                  out_valid  <= 1'b1;
                  pair_idx   <= cnt_reg;
                  frame_done <= last_blk;
                  if (last_blk) state_reg <= FILL;
               end
               default: state_reg <= FILL;
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_lane
         logic signed [WIDTH-1:0] mem_re [DEPTH];
         logic signed [WIDTH-1:0] mem_im [DEPTH];
         logic signed [WIDTH-1:0] d1_re_reg;
         logic signed [WIDTH-1:0] d1_im_reg;
         logic signed [WIDTH-1:0] d2_re_reg;
         logic signed [WIDTH-1:0] d2_im_reg;

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem_re[cnt_reg] <= din_re[gi];
               mem_im[cnt_reg] <= din_im[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               d1_re_reg <= '0;
               d1_im_reg <= '0;
               d2_re_reg <= '0;
               d2_im_reg <= '0;
            end else if (rd_en) begin
               d1_re_reg <= mem_re[cnt_reg];
               d1_im_reg <= mem_im[cnt_reg];
               d2_re_reg <= din_re[gi];
               d2_im_reg <= din_im[gi];
            end
         end

         assign dout1_re[gi] = d1_re_reg;
         assign dout1_im[gi] = d1_im_reg;
         assign dout2_re[gi] = d2_re_reg;
         assign dout2_im[gi] = d2_im_reg;
      end
   endgenerate

endmodule

// File: tb/tb_bfly_pair_buf.sv
// Directed bench for bfly_pair_buf: a vector table of per-cycle stimulus and
// expected outputs, plus a hand-written flush-on-last-pair sequence.
module tb_bfly_pair_buf;

   localparam int W = 9;
   localparam int D = 4;

   logic                clk;
   logic                rst;
   logic                flush;
   logic                in_valid;
   logic signed [W-1:0] din_re   [15:0];
   logic signed [W-1:0] din_im   [15:0];
   logic                out_valid;
   logic signed [W-1:0] dout1_re [15:0];
   logic signed [W-1:0] dout1_im [15:0];
   logic signed [W-1:0] dout2_re [15:0];
   logic signed [W-1:0] dout2_im [15:0];
   logic [1:0]          pair_idx;
   logic                frame_done;

   bfly_pair_buf #(.INT(3), .FLT(6), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .din_re     (din_re),
      .din_im     (din_im),
      .out_valid  (out_valid),
      .dout1_re   (dout1_re),
      .dout1_im   (dout1_im),
      .dout2_re   (dout2_re),
      .dout2_im   (dout2_im),
      .pair_idx   (pair_idx),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // chk: 0 = control only, 1 = pair data/idx, 2 = all data outputs zero
   typedef struct {
      bit rst;
      bit flush;
      bit iv;
      int blk;
      bit ev;
      bit ed;
      int idx;
      int b1;
      int b2;
      int chk;
   } vec_t;

   vec_t tv[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Lane value of block b: ids < 32 follow the b*16+k ramp, ids >= 32 are
   // alternating full-scale extremes.
   function automatic logic signed [W-1:0] lv(int b, int k, bit im);
      int t;
      int s;
      if (b >= 32) begin
         s = ((b - 32) ^ (k % 2)) & 1;
         if (im) t = (s != 0) ? -256 : 255;
         else    t = (s != 0) ? 255 : -256;
      end else begin
         t = b * 16 + k;
         if (im) t = -t;
      end
      return t[W-1:0];
   endfunction

   task automatic cmp(string nm, int vi, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s (vec %0d): got %0d, expected %0d", nm, vi, got, exp);
      end
   endtask

   task automatic add(bit r, bit f, bit iv, int blk, bit ev, bit ed,
                      int idx, int b1, int b2, int chk);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.blk = blk;
      v.ev = ev; v.ed = ed; v.idx = idx; v.b1 = b1; v.b2 = b2; v.chk = chk;
      tv.push_back(v);
   endtask

   function automatic int fid(int base, bit extreme, int i);
      return extreme ? 32 + ((i + i / 4) % 2) : base + i;
   endfunction

   // One full frame of 2*D blocks, optionally with a bubble after each block.
   task automatic add_frame(int base, bit bub, bit extreme);
      int id;
      for (int i = 0; i < 2 * D; i++) begin
         id = fid(base, extreme, i);
         if (i < D) add(0, 0, 1, id, 0, 0, 0, 0, 0, 0);
         else       add(0, 0, 1, id, 1, i == 2 * D - 1, i - D, fid(base, extreme, i - D), id, 1);
         if (bub) begin
            if (i < D) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            else       add(0, 0, 0, 0, 0, 0, i - D, fid(base, extreme, i - D), id, 1);
         end
      end
   endtask

   task automatic step(bit r, bit f, bit iv, int blk);
      rst      = r;
      flush    = f;
      in_valid = iv;
      for (int k = 0; k < 16; k++) begin
         din_re[k] = lv(blk, k, 1'b0);
         din_im[k] = lv(blk, k, 1'b1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_data(int vi, int idx, int b1, int b2, bit zero);
      cmp("pair_idx", vi, int'(pair_idx), zero ? 0 : idx);
      for (int k = 0; k < 16; k++) begin
         cmp($sformatf("dout1_re[%0d]", k), vi, int'(dout1_re[k]), zero ? 0 : int'(lv(b1, k, 1'b0)));
         cmp($sformatf("dout1_im[%0d]", k), vi, int'(dout1_im[k]), zero ? 0 : int'(lv(b1, k, 1'b1)));
         cmp($sformatf("dout2_re[%0d]", k), vi, int'(dout2_re[k]), zero ? 0 : int'(lv(b2, k, 1'b0)));
         cmp($sformatf("dout2_im[%0d]", k), vi, int'(dout2_im[k]), zero ? 0 : int'(lv(b2, k, 1'b1)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         din_re[k] = '0;
         din_im[k] = '0;
      end

      // reset held three cycles
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      // basic pairing, then the same frame with bubbles
      add_frame(0, 0, 0);
      add_frame(0, 1, 0);
      // two back-to-back frames
      add_frame(0, 0, 0);
      add_frame(8, 0, 0);
      // flush with a valid block after 6 blocks, then a clean frame
      for (int i = 0; i < 6; i++)
         add(0, 0, 1, i, i >= D, 0, i - D, i - D, i, (i >= D) ? 1 : 0);
      add(0, 1, 1, 9, 0, 0, 0, 0, 0, 0);
      add_frame(2, 0, 0);
      // reset during PAIR after 5 blocks, then a frame of extreme values
      for (int i = 0; i < 5; i++)
         add(0, 0, 1, i, i >= D, 0, i - D, i - D, i, (i >= D) ? 1 : 0);
      add(1, 0, 1, 7, 0, 0, 0, 0, 0, 2);
      add_frame(0, 0, 1);

      for (int vi = 0; vi < tv.size(); vi++) begin
         step(tv[vi].rst, tv[vi].flush, tv[vi].iv, tv[vi].blk);
         cmp("out_valid", vi, int'(out_valid), int'(tv[vi].ev));
         cmp("frame_done", vi, int'(frame_done), int'(tv[vi].ed));
         if (tv[vi].chk == 1) check_data(vi, tv[vi].idx, tv[vi].b1, tv[vi].b2, 1'b0);
         if (tv[vi].chk == 2) check_data(vi, 0, 0, 0, 1'b1);
         $display("vec %0d: rst=%0b flush=%0b iv=%0b blk=%0d -> out_valid=%0b pair_idx=%0d frame_done=%0b",
                  vi, tv[vi].rst, tv[vi].flush, tv[vi].iv, tv[vi].blk, out_valid, pair_idx, frame_done);
      end

      // Flush arriving with the final second-half block: no pair, no frame_done,
      // and the next frame restarts cleanly at pair_idx 0.
      for (int i = 0; i < 2 * D - 1; i++) step(0, 0, 1, 16 + i);
      cmp("last_pair_before_flush_idx", 1000, int'(pair_idx), D - 2);
      step(0, 1, 1, 16 + 2 * D - 1);
      cmp("flush_last_out_valid", 1001, int'(out_valid), 0);
      cmp("flush_last_frame_done", 1001, int'(frame_done), 0);
      $display("hand seq: flush on last pair -> out_valid=%0b frame_done=%0b", out_valid, frame_done);
      for (int i = 0; i < 2 * D; i++) begin
         step(0, 0, 1, 5 + i);
         cmp("post_flush_out_valid", 1002 + i, int'(out_valid), (i >= D) ? 1 : 0);
         cmp("post_flush_frame_done", 1002 + i, int'(frame_done), (i == 2 * D - 1) ? 1 : 0);
         if (i >= D) check_data(1002 + i, i - D, 5 + i - D, 5 + i, 1'b0);
         $display("hand seq blk %0d: out_valid=%0b pair_idx=%0d frame_done=%0b",
                  5 + i, out_valid, pair_idx, frame_done);
      end
      step(0, 0, 0, 0);
      cmp("idle_out_valid", 1100, int'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
